// File: rtl/gnn_job_ctrl_pkg.sv
// Shared types, field widths and packed-bus index helpers for the GNN job sequencer.
package gnn_job_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } ctrl_state_t;

    localparam int NUM_NODES = 4;
    localparam int X_W       = 5;
    localparam int W_W       = 5;
    localparam int OUT_W     = 21;

    localparam int NUM_X     = NUM_NODES * 4;
    localparam int NUM_WGT   = 24;
    localparam int NUM_OUT   = NUM_NODES * 2;

    localparam int X_BUS_W   = NUM_X * X_W;
    localparam int W_BUS_W   = NUM_WGT * W_W;
    localparam int OUT_BUS_W = NUM_OUT * OUT_W;
    localparam int DONE_W    = NUM_OUT;

    function automatic int x_idx(input int n, input int i);
        return X_W * (4 * n + i);
    endfunction

    function automatic int w_idx(input int k);
        return W_W * k;
    endfunction

    function automatic int out_idx(input int n, input int j);
        return OUT_W * (2 * n + j);
    endfunction

    function automatic int done_idx(input int n, input int j);
        return 2 * n + j;
    endfunction

endpackage

// File: rtl/gnn_job_ctrl_if.sv
// Job, datapath and result signal bundle; master is the host/datapath side, slave is the controller.
interface gnn_job_ctrl_if;
    import gnn_job_ctrl_pkg::*;

    logic                 job_valid;
    logic                 job_ready;
    logic [X_BUS_W-1:0]   job_x;
    logic [W_BUS_W-1:0]   job_w;
    logic [3:0]           job_tag;

    logic [X_BUS_W-1:0]   dp_x;
    logic [W_BUS_W-1:0]   dp_w;
    logic                 dp_in_ready;
    logic [OUT_BUS_W-1:0] dp_out;
    logic [DONE_W-1:0]    dp_done;

    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_BUS_W-1:0] res_data;
    logic [3:0]           res_tag;
    logic                 res_err;
    logic [DONE_W-1:0]    res_miss;

    logic                 busy;
    logic [15:0]          job_count;
    logic [7:0]           err_count;

    modport master (
        output job_valid, job_x, job_w, job_tag, dp_out, dp_done, res_ready,
        input  job_ready, dp_x, dp_w, dp_in_ready, res_valid, res_data, res_tag,
               res_err, res_miss, busy, job_count, err_count
    );

    modport slave (
        input  job_valid, job_x, job_w, job_tag, dp_out, dp_done, res_ready,
        output job_ready, dp_x, dp_w, dp_in_ready, res_valid, res_data, res_tag,
               res_err, res_miss, busy, job_count, err_count
    );

endinterface

// File: rtl/gnn_watchdog.sv
// Clearable up-counter bounding the WAIT phase; flags the first cycle after clear and the last allowed cycle.
module gnn_watchdog #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TCNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [TCNT_W-1:0] cnt,
    output logic              first,
    output logic              expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != TCNT_W'(TIMEOUT_CYCLES)) begin
            cnt <= cnt + TCNT_W'(1);
        end
    end

    assign first  = (cnt == '0);
    assign expire = (cnt == TCNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gnn_job_ctrl.sv
// Job sequencer: accepts one job, strobes the datapath, waits for all done flags under a watchdog,
// then holds the result until the consumer takes it.
module gnn_job_ctrl
    import gnn_job_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TCNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic          clk,
    input logic          rst_n,
    gnn_job_ctrl_if.slave bus
);

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;

    logic              take_job;
    logic              done_hit;
    logic              abort_hit;
    logic              res_hs;
    logic              wd_clr;
    logic              wd_inc;
    logic              wd_first;
    logic              wd_expire;
    logic [TCNT_W-1:0] wd_cnt;
    logic [3:0]        tag_q;

    gnn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TCNT_W         (TCNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .cnt    (wd_cnt),
        .first  (wd_first),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_job  = 1'b0;
        done_hit  = 1'b0;
        abort_hit = 1'b0;
        res_hs    = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    take_job = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_inc = 1'b1;
                // The first WAIT cycle may still see the previous job's flags.
                if (!wd_first && (&bus.dp_done)) begin
                    done_hit = 1'b1;
                    state_d  = RESULT;
                end else if (wd_expire) begin
                    abort_hit = 1'b1;
                    state_d   = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.job_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.dp_in_ready = (state_q == LAUNCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dp_x      <= '0;
            bus.dp_w      <= '0;
            tag_q         <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_tag   <= '0;
            bus.res_err   <= 1'b0;
            bus.res_miss  <= '0;
            bus.job_count <= '0;
            bus.err_count <= '0;
        end else begin
            if (take_job) begin
                bus.dp_x <= bus.job_x;
                bus.dp_w <= bus.job_w;
                tag_q    <= bus.job_tag;
            end
            if (done_hit) begin
                bus.res_valid <= 1'b1;
                bus.res_data  <= bus.dp_out;
                bus.res_tag   <= tag_q;
                bus.res_err   <= 1'b0;
                bus.res_miss  <= '0;
            end else if (abort_hit) begin
                bus.res_valid <= 1'b1;
                bus.res_data  <= '0;
                bus.res_tag   <= tag_q;
                bus.res_err   <= 1'b1;
                bus.res_miss  <= ~bus.dp_done;
            end
            if (res_hs) begin
                bus.res_valid <= 1'b0;
                if (!bus.res_err) begin
                    bus.job_count <= bus.job_count + 16'd1;
                end else if (bus.err_count != 8'hFF) begin
                    bus.err_count <= bus.err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gnn_job_ctrl.sv
// Directed bench for gnn_job_ctrl with a simple delay-programmable datapath model.
module tb_gnn_job_ctrl;
    import gnn_job_ctrl_pkg::*;

    localparam int CW = 168;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gnn_job_ctrl_if bus ();

    gnn_job_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Datapath model: cycles since the strobe, done pattern and output lanes.
    int         since      = 0;
    int         strobe_cnt = 0;
    int         dly        = 1000;
    int         stale_n    = 0;
    logic [7:0] base       = 8'h00;
    int         out_base   = 0;
    int         stale_base = 0;

    function automatic logic [167:0] mk_out(input int b);
        logic [167:0] v;
        v = '0;
        for (int l = 0; l < 8; l++) v[out_idx(l / 2, l % 2) +: 21] = 21'(b + l);
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (bus.dp_in_ready) begin
            since      <= 1;
            strobe_cnt <= strobe_cnt + 1;
        end else begin
            since <= since + 1;
        end
    end

    always_comb begin
        bus.dp_done = base;
        bus.dp_out  = mk_out(stale_base);
        if (since >= dly) begin
            bus.dp_done = 8'hFF;
            bus.dp_out  = mk_out(out_base);
        end else if (since <= stale_n) begin
            bus.dp_done = 8'hFF;
        end
    end

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic submit(input logic [79:0] x, input logic [119:0] w, input logic [3:0] t);
        bus.job_x     = x;
        bus.job_w     = w;
        bus.job_tag   = t;
        bus.job_valid = 1'b1;
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int lat);
        int k;
        k = 0;
        while (!bus.res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, CW'(bus.res_valid), CW'(1));
        chk({tag, "_lat"}, CW'(since), CW'(lat));
    endtask

    task automatic release_res();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    logic [79:0]  x_ones, x_neg;
    logic [119:0] w_ones;
    logic [167:0] held;
    int           s0;

    initial begin
        rst_n         = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_x     = '0;
        bus.job_w     = '0;
        bus.job_tag   = '0;
        bus.res_ready = 1'b0;
        x_ones = '0;
        x_neg  = '0;
        w_ones = '0;
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 4; i++) begin
                x_ones[x_idx(n, i) +: 5] = 5'sd1;
                x_neg[x_idx(n, i) +: 5]  = -5'sd1;
            end
        for (int k = 0; k < 24; k++) w_ones[w_idx(k) +: 5] = 5'sd1;

        repeat (2) @(negedge clk);
        chk("rst_job_ready", CW'(bus.job_ready), CW'(1));
        chk("rst_busy", CW'(bus.busy), CW'(0));
        chk("rst_dp_x", CW'(bus.dp_x), CW'(0));
        chk("rst_res_valid", CW'(bus.res_valid), CW'(0));
        chk("rst_job_count", CW'(bus.job_count), CW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal job, done 4 cycles after the strobe.
        dly = 4; out_base = 100; stale_base = 100; base = 8'h00;
        submit(x_ones, w_ones, 4'd5);
        chk("nom_strobe", CW'(bus.dp_in_ready), CW'(1));
        chk("nom_job_ready", CW'(bus.job_ready), CW'(0));
        chk("nom_dp_x", CW'(bus.dp_x), CW'(x_ones));
        chk("nom_dp_w", CW'(bus.dp_w), CW'(w_ones));
        wait_res("nom", 5);
        chk("nom_data", bus.res_data, mk_out(100));
        chk("nom_tag", CW'(bus.res_tag), CW'(5));
        chk("nom_err", CW'(bus.res_err), CW'(0));
        chk("nom_miss", CW'(bus.res_miss), CW'(0));
        chk("nom_strobes", CW'(strobe_cnt), CW'(1));
        release_res();
        chk("nom_job_count", CW'(bus.job_count), CW'(1));
        chk("nom_res_valid_low", CW'(bus.res_valid), CW'(0));
        chk("nom_dp_x_hold", CW'(bus.dp_x), CW'(x_ones));

        // Stale flags in the first WAIT cycle must not be captured.
        dly = 5; stale_n = 1; out_base = 200; stale_base = 300;
        submit(x_neg, w_ones, 4'd6);
        chk("stale_dp_x", CW'(bus.dp_x), CW'(x_neg));
        wait_res("stale", 6);
        chk("stale_data", bus.res_data, mk_out(200));
        chk("stale_tag", CW'(bus.res_tag), CW'(6));
        release_res();
        stale_n = 0;
        chk("stale_job_count", CW'(bus.job_count), CW'(2));

        // Timeout with half the flags stuck low.
        dly = 1000; base = 8'h0F;
        submit(x_ones, w_ones, 4'd7);
        wait_res("tmo", 17);
        chk("tmo_err", CW'(bus.res_err), CW'(1));
        chk("tmo_miss", CW'(bus.res_miss), CW'(8'hF0));
        chk("tmo_data", bus.res_data, CW'(0));
        chk("tmo_tag", CW'(bus.res_tag), CW'(7));
        release_res();
        chk("tmo_err_count", CW'(bus.err_count), CW'(1));
        chk("tmo_job_count", CW'(bus.job_count), CW'(2));

        // Backpressure on the result with a job queued behind it.
        base = 8'h00; dly = 3; out_base = 400; stale_base = 400;
        submit(x_neg, w_ones, 4'd8);
        wait_res("bp", 4);
        held = bus.res_data;
        chk("bp_data", held, mk_out(400));
        s0 = strobe_cnt;
        bus.job_x = x_ones; bus.job_tag = 4'd9; bus.job_valid = 1'b1;
        dly = 16; out_base = 500; stale_base = 501;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_res_valid", CW'(bus.res_valid), CW'(1));
            chk("bp_job_ready", CW'(bus.job_ready), CW'(0));
            chk("bp_data_stable", bus.res_data, held);
            chk("bp_tag_stable", CW'(bus.res_tag), CW'(8));
        end
        chk("bp_no_strobe", CW'(strobe_cnt), CW'(s0));
        release_res();
        chk("bp_idle", CW'(bus.job_ready), CW'(1));
        chk("bp_res_valid_low", CW'(bus.res_valid), CW'(0));
        chk("bp_job_count", CW'(bus.job_count), CW'(3));
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk("bp_queued_strobe", CW'(bus.dp_in_ready), CW'(1));
        chk("bp_queued_dp_x", CW'(bus.dp_x), CW'(x_ones));

        // Queued job: done first asserts in the last WAIT cycle.
        wait_res("same", 17);
        chk("same_err", CW'(bus.res_err), CW'(0));
        chk("same_data", bus.res_data, mk_out(500));
        chk("same_tag", CW'(bus.res_tag), CW'(9));
        release_res();
        chk("same_job_count", CW'(bus.job_count), CW'(4));
        chk("same_err_count", CW'(bus.err_count), CW'(1));

        // Reset during WAIT.
        dly = 1000; base = 8'h00;
        submit(x_neg, w_ones, 4'hA);
        repeat (3) @(negedge clk);
        chk("mid_busy", CW'(bus.busy), CW'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", CW'(bus.busy), CW'(0));
        chk("mid_rst_job_ready", CW'(bus.job_ready), CW'(1));
        chk("mid_rst_dp_x", CW'(bus.dp_x), CW'(0));
        chk("mid_rst_dp_w", CW'(bus.dp_w), CW'(0));
        chk("mid_rst_res_tag", CW'(bus.res_tag), CW'(0));
        chk("mid_rst_job_count", CW'(bus.job_count), CW'(0));
        chk("mid_rst_err_count", CW'(bus.err_count), CW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dly = 4; out_base = 600; stale_base = 600;
        submit(x_ones, w_ones, 4'hB);
        wait_res("post", 5);
        chk("post_data", bus.res_data, mk_out(600));
        chk("post_tag", CW'(bus.res_tag), CW'(11));
        release_res();
        chk("post_job_count", CW'(bus.job_count), CW'(1));
        chk("post_err_count", CW'(bus.err_count), CW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
